// File: rtl/gcd_lcm_coproc.sv
// Memory-mapped GCD/LCM coprocessor: binary (Stein) GCD, then restoring divide
// and shift-add multiply to form LCM = (OPA / gcd) * OPB.
module gcd_lcm_coproc #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, CHK, STRIP, GLOOP, FIX, DIV, MUL, FIN} state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   opa_reg, opb_reg, la_reg, lb_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, g_reg, q_reg, rem_reg;
  logic [2*WIDTH-1:0] prod_reg, mcand_reg, res_reg;
  logic               mode_reg, lmode_reg, irq_en_reg;
  logic               busy_reg, done_reg, err_reg, irq_reg;
  logic [5:0]         k_reg, cnt_reg;

  logic [5:0]         word_hit;
  logic               wr_opa, wr_opb, wr_ctrl, start_ok;
  logic [63:0]        res_wide;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff, g_val;
  logic               unused_adr_bits;

  assign sel = (DataAdr[31:5] == BASE_ADDR[31:5]) && (DataAdr[4:2] <= 3'd5);

  for (genvar gi = 0; gi < 6; gi++) begin : g_hit
    assign word_hit[gi] = sel && (DataAdr[4:2] == 3'(gi));
  end

  assign wr_opa          = MemWrite && word_hit[0];
  assign wr_opb          = MemWrite && word_hit[1];
  assign wr_ctrl         = MemWrite && word_hit[2];
  assign start_ok        = wr_ctrl && WriteData[0] && !busy_reg;
  assign unused_adr_bits = ^DataAdr[1:0];
  assign irq             = irq_reg;
  assign res_wide        = 64'(res_reg);

  // One restoring-division step: remainder never exceeds g, so the
  // difference fits in WIDTH bits when rem_shift >= g.
  assign rem_shift = {rem_reg, q_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, g_reg};
  assign rem_diff  = rem_shift[WIDTH-1:0] - g_reg;
  assign g_val     = a_reg << k_reg;

  always_comb begin
    ReadData = 32'd0;
    if (sel) begin
      case (DataAdr[4:2])
        3'd0:    ReadData = 32'(opa_reg);
        3'd1:    ReadData = 32'(opb_reg);
        3'd2:    ReadData = {29'd0, irq_en_reg, mode_reg, 1'b0};
        3'd3:    ReadData = {29'd0, err_reg, done_reg, busy_reg};
        3'd4:    ReadData = res_wide[31:0];
        3'd5:    ReadData = res_wide[63:32];
        default: ReadData = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      opa_reg    <= '0;
      opb_reg    <= '0;
      la_reg     <= '0;
      lb_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      g_reg      <= '0;
      q_reg      <= '0;
      rem_reg    <= '0;
      prod_reg   <= '0;
      mcand_reg  <= '0;
      res_reg    <= '0;
      mode_reg   <= 1'b0;
      lmode_reg  <= 1'b0;
      irq_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      irq_reg    <= 1'b0;
      k_reg      <= '0;
      cnt_reg    <= '0;
    end else begin
      irq_reg <= done_reg & irq_en_reg;
      if (wr_opa && !busy_reg) opa_reg <= WriteData[WIDTH-1:0];
      if (wr_opb && !busy_reg) opb_reg <= WriteData[WIDTH-1:0];
      if (wr_ctrl) begin
        irq_en_reg <= WriteData[2];
        if (!busy_reg) mode_reg <= WriteData[1];
      end

      if (start_ok) begin
        // Mode written together with start applies to this run.
        la_reg    <= opa_reg;
        lb_reg    <= opb_reg;
        lmode_reg <= WriteData[1];
        a_reg     <= opa_reg;
        b_reg     <= opb_reg;
        k_reg     <= '0;
        busy_reg  <= 1'b1;
        done_reg  <= 1'b0;
        err_reg   <= 1'b0;
        res_reg   <= '0;
        state_reg <= CHK;
      end else begin
        case (state_reg)
          IDLE: ;
          CHK: begin
            if (a_reg == '0 && b_reg == '0) begin
              prod_reg  <= '0;
              err_reg   <= 1'b1;
              state_reg <= FIN;
            end else if (a_reg == '0) begin
              prod_reg  <= lmode_reg ? '0 : {{WIDTH{1'b0}}, b_reg};
              state_reg <= FIN;
            end else if (b_reg == '0) begin
              prod_reg  <= lmode_reg ? '0 : {{WIDTH{1'b0}}, a_reg};
              state_reg <= FIN;
            end else begin
              state_reg <= STRIP;
            end
          end
          STRIP: begin
            if (!a_reg[0] && !b_reg[0]) begin
              a_reg <= a_reg >> 1;
              b_reg <= b_reg >> 1;
              k_reg <= k_reg + 6'd1;
            end else begin
              state_reg <= GLOOP;
            end
          end
          GLOOP: begin
            if (!a_reg[0])          a_reg <= a_reg >> 1;
            else if (!b_reg[0])     b_reg <= b_reg >> 1;
            else if (a_reg > b_reg) a_reg <= a_reg - b_reg;
            else if (b_reg > a_reg) b_reg <= b_reg - a_reg;
            else                    state_reg <= FIX;
          end
          FIX: begin
            g_reg <= g_val;
            if (!lmode_reg) begin
              prod_reg  <= {{WIDTH{1'b0}}, g_val};
              state_reg <= FIN;
            end else begin
              q_reg     <= la_reg;
              rem_reg   <= '0;
              cnt_reg   <= CNT_LAST;
              state_reg <= DIV;
            end
          end
          DIV: begin
            if (rem_ge) begin
              rem_reg <= rem_diff;
              q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
              rem_reg <= rem_shift[WIDTH-1:0];
              q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
            end
            if (cnt_reg == 6'd0) begin
              cnt_reg   <= CNT_LAST;
              mcand_reg <= {{WIDTH{1'b0}}, lb_reg};
              prod_reg  <= '0;
              state_reg <= MUL;
            end else begin
              cnt_reg <= cnt_reg - 6'd1;
            end
          end
          MUL: begin
            // q_reg now holds the quotient and is consumed LSB first.
            if (q_reg[0]) prod_reg <= prod_reg + mcand_reg;
            mcand_reg <= mcand_reg << 1;
            q_reg     <= q_reg >> 1;
            if (cnt_reg == 6'd0) state_reg <= FIN;
            else                 cnt_reg   <= cnt_reg - 6'd1;
          end
          FIN: begin
            res_reg   <= prod_reg;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed self-checking bench for gcd_lcm_coproc through its register window.
module tb_gcd_lcm_coproc;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] OFF_OPA = 32'h00, OFF_OPB = 32'h04, OFF_CTRL = 32'h08;
  localparam logic [31:0] OFF_ST = 32'h0C, OFF_LO = 32'h10, OFF_HI = 32'h14;
  localparam int GCD_BUDGET = 132;
  localparam int LCM_BUDGET = 198;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = BASE;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        sel;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd_lcm_coproc #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sel      (sel),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk);
    DataAdr   = BASE + off;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
    MemWrite = 1'b0;
    DataAdr  = BASE + off;
    #1;
    data = ReadData;
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic seen);
    logic [31:0] st;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      bus_read(OFF_ST, st);
      seen = st[1];
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ctrl, input int budget,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_st);
    logic [31:0] r, lo, hi, st;
    int          cyc;
    logic        seen;
    bus_write(OFF_OPA, a);
    bus_write(OFF_OPB, b);
    bus_write(OFF_CTRL, ctrl);
    bus_read(OFF_ST, r);
    check({tag, " busy"}, r, 32'd1);
    bus_read(OFF_LO, r);
    check({tag, " res_clr"}, r, 32'd0);
    wait_done(budget, cyc, seen);
    check({tag, " done_in_budget"}, 32'(seen), 32'd1);
    bus_read(OFF_LO, lo);
    bus_read(OFF_HI, hi);
    bus_read(OFF_ST, st);
    check({tag, " res_lo"}, lo, exp_lo);
    check({tag, " res_hi"}, hi, exp_hi);
    check({tag, " status"}, st, exp_st);
    $display("op %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h st=%0d cycles=%0d",
             tag, a, b, hi, lo, st, cyc);
  endtask

  initial begin
    logic [31:0] r;
    int          cyc;
    logic        seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Power-up state and address decode
    bus_read(OFF_OPA, r);  check("rst opa", r, 32'd0);
    bus_read(OFF_CTRL, r); check("rst ctrl", r, 32'd0);
    bus_read(OFF_ST, r);   check("rst status", r, 32'd0);
    bus_read(OFF_LO, r);   check("rst res_lo", r, 32'd0);
    check("rst sel_hi", 32'(sel), 32'd1);
    check("rst irq", 32'(irq), 32'd0);
    bus_read(32'h18, r);
    check("sel off_window", 32'(sel), 32'd0);
    $display("txn reset/decode checks done");

    run_op("gcd48_18", 32'd48, 32'd18, 32'h1, GCD_BUDGET, 32'd6, 32'd0, 32'd2);

    run_op("lcm4_6", 32'd4, 32'd6, 32'h7, LCM_BUDGET, 32'd12, 32'd0, 32'd2);
    bus_read(OFF_CTRL, r);
    check("lcm4_6 ctrl", r, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    check("lcm4_6 irq", 32'(irq), 32'd1);

    run_op("lcm_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h3, LCM_BUDGET,
           32'h0000_0002, 32'hFFFF_FFFD, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("lcm_big irq_off", 32'(irq), 32'd0);

    run_op("gcd0_0", 32'd0, 32'd0, 32'h1, 3, 32'd0, 32'd0, 32'd6);
    run_op("gcd0_7", 32'd0, 32'd7, 32'h1, GCD_BUDGET, 32'd7, 32'd0, 32'd2);
    run_op("lcm0_7", 32'd0, 32'd7, 32'h3, LCM_BUDGET, 32'd0, 32'd0, 32'd2);
    run_op("lcm12_18", 32'd12, 32'd18, 32'h3, LCM_BUDGET, 32'd36, 32'd0, 32'd2);
    run_op("gcd1024_96", 32'd1024, 32'd96, 32'h1, GCD_BUDGET, 32'd32, 32'd0, 32'd2);

    // Writes and a second start while busy are ignored
    bus_write(OFF_OPA, 32'd48);
    bus_write(OFF_OPB, 32'd18);
    bus_write(OFF_CTRL, 32'h1);
    bus_write(OFF_OPA, 32'd5);
    bus_write(OFF_CTRL, 32'h3);
    bus_read(OFF_OPA, r);
    check("busy opa_kept", r, 32'd48);
    bus_read(OFF_CTRL, r);
    check("busy mode_kept", r, 32'd0);
    wait_done(GCD_BUDGET, cyc, seen);
    check("busy done", 32'(seen), 32'd1);
    bus_read(OFF_LO, r);
    check("busy res_lo", r, 32'd6);
    $display("txn busy-ignore gcd(48,18) res=0x%08h cycles=%0d", r, cyc);

    // Reset in the middle of an LCM run
    bus_write(OFF_OPA, 32'd4);
    bus_write(OFF_OPB, 32'd6);
    bus_write(OFF_CTRL, 32'h3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    bus_read(OFF_ST, r);  check("midrst status", r, 32'd0);
    bus_read(OFF_LO, r);  check("midrst res_lo", r, 32'd0);
    bus_read(OFF_HI, r);  check("midrst res_hi", r, 32'd0);
    bus_read(OFF_OPA, r); check("midrst opa", r, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_done(300, cyc, seen);
    check("midrst no_done", 32'(seen), 32'd0);
    $display("txn mid-op reset, done after release=%0d", seen);

    run_op("post_rst_gcd", 32'd48, 32'd18, 32'h1, GCD_BUDGET, 32'd6, 32'd0, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
